dac_ddr_tx: RTL and testbench

- Transmit-side counterpart to the ADS5404 capture path: drives a dual-channel, 12-bit, DDR-LVDS parallel DAC from user logic.
- Takes two samples per channel per fabric clock and serialises them onto the pins with ODDRs.
- Forwards a DDR-aligned line clock to the DAC.
- Sequences DAC reset, settle, sync pulse and enable through an internal FSM.
- Sits between the user datapath (yellow-block side) and the DAC pins.

---
 rtl/dac_ddr_tx.sv | 140 ++++++++++++++
 tb/tb_dac_ddr_tx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_ddr_tx.sv
// dac_ddr_tx: dual-channel DDR-LVDS DAC transmitter with reset/settle/sync bring-up FSM.
// Optional macro DAC_DDR_TX_RAMP_EN adds a user_ramp-selected internal ramp source.
module dac_ddr_tx #(
  parameter int NBITS         = 12,
  parameter int RST_CYCLES    = 64,
  parameter int SETTLE_CYCLES = 256,
  parameter int SYNC_LEN      = 16,
  parameter bit OFFSET_BINARY = 1
) (
  input  logic             clk,
  input  logic             user_rst,
  input  logic             user_start,
  input  logic             user_sync_req,
`ifdef DAC_DDR_TX_RAMP_EN
  input  logic             user_ramp,
`endif
  input  logic             data_valid,
  input  logic [NBITS-1:0] da_0,
  input  logic [NBITS-1:0] da_1,
  input  logic [NBITS-1:0] db_0,
  input  logic [NBITS-1:0] db_1,
  output logic             ready,
  output logic [2:0]       state,
  output logic [15:0]      underflow_cnt,
  output logic             sreset,
  output logic             txenable,
  output logic             sync_p,
  output logic             sync_n,
  output logic             dacclk_p,
  output logic             dacclk_n,
  output logic [NBITS-1:0] da_p,
  output logic [NBITS-1:0] da_n,
  output logic [NBITS-1:0] db_p,
  output logic [NBITS-1:0] db_n
);
  localparam int MAXC = RST_CYCLES > SETTLE_CYCLES ? (RST_CYCLES > SYNC_LEN ? RST_CYCLES : SYNC_LEN)
                                                   : (SETTLE_CYCLES > SYNC_LEN ? SETTLE_CYCLES : SYNC_LEN);
  localparam int CW = MAXC > 2 ? $clog2(MAXC) : 1;
  localparam int W = 4 * NBITS;
  localparam logic [NBITS-1:0] MSB = {OFFSET_BINARY, {(NBITS-1){1'b0}}};
  localparam logic [W-1:0] MID = {4{MSB}};
  typedef enum logic [2:0] {S_IDLE, S_RESET, S_SETTLE, S_SYNC, S_RUN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, lim;
  logic done;
  logic sreset_q, sreset_d, txen_q, txen_d, sync_q, sync_d, ready_q, ready_d;
  logic [W-1:0] src, s1_q, s1_d, s2_q, oddr_q;
  logic [15:0] uf_q, uf_d;
  logic run, vld;
  always_ff @(posedge clk) begin
    if (user_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sreset_q <= 1'b1;
      txen_q   <= 1'b0;
      sync_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sreset_q <= sreset_d;
      txen_q   <= txen_d;
      sync_q   <= sync_d;
      ready_q  <= ready_d;
    end
  end
  always_comb begin
    lim = state_q == S_RESET  ? CW'(RST_CYCLES - 1) :
          state_q == S_SETTLE ? CW'(SETTLE_CYCLES - 1) : CW'(SYNC_LEN - 1);
    done = cnt_q == lim;
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (user_start) state_d = S_RESET;
      S_RESET:  if (done) state_d = S_SETTLE;
      S_SETTLE: if (done) state_d = S_SYNC;
      S_SYNC:   if (done) state_d = S_RUN;
      S_RUN:    if (user_sync_req) state_d = S_SYNC;
      default:  state_d = S_IDLE;
    endcase
    cnt_d = (state_d != state_q || state_q == S_IDLE || state_q == S_RUN) ? '0 : cnt_q + CW'(1);
  end
  // Control outputs are registered from the next state so they change on the transition edge.
  always_comb begin
    sreset_d = state_d != S_RESET;
    sync_d   = state_d == S_SYNC;
    ready_d  = state_d == S_RUN;
    txen_d   = state_d == S_RUN || (state_d == S_SYNC && txen_q);
  end
  assign run = state_q == S_RUN;
`ifdef DAC_DDR_TX_RAMP_EN
  logic [NBITS-1:0] ramp_q, ramp_d, ramp_1;
  logic ramp_on;
  always_ff @(posedge clk) begin
    if (user_rst) ramp_q <= '0;
    else ramp_q <= ramp_d;
  end
  always_comb begin
    ramp_on = run && user_ramp;
    ramp_1  = ramp_q + NBITS'(1);
    ramp_d  = !run ? '0 : ramp_on ? ramp_q + NBITS'(2) : ramp_q;
  end
  assign vld = data_valid || ramp_on;
  assign src = ramp_on ? {ramp_q, ramp_1, ramp_q, ramp_1} : {da_0, da_1, db_0, db_1};
`else
  assign vld = data_valid;
  assign src = {da_0, da_1, db_0, db_1};
`endif
  always_comb begin
    s1_d = (run && vld) ? src : '0;
    uf_d = (run && !vld && uf_q != 16'hFFFF) ? uf_q + 16'd1 : uf_q;
  end
  // s1 holds two's-complement words, s2 the pin format, oddr_q the SAME_EDGE ODDR capture.
  always_ff @(posedge clk) begin
    if (user_rst) begin
      s1_q   <= '0;
      s2_q   <= MID;
      oddr_q <= MID;
      uf_q   <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s1_q ^ MID;
      oddr_q <= s2_q;
      uf_q   <= uf_d;
    end
  end
  assign da_p = clk ? oddr_q[W-1 -: NBITS] : oddr_q[3*NBITS-1 -: NBITS];
  assign db_p = clk ? oddr_q[2*NBITS-1 -: NBITS] : oddr_q[NBITS-1:0];
  assign da_n = ~da_p;
  assign db_n = ~db_p;
  // Forwarded clock is an ODDR with D1=1, D2=0, which reduces to the fabric clock itself.
  assign dacclk_p = clk;
  assign dacclk_n = ~clk;
  assign sync_p = sync_q;
  assign sync_n = ~sync_q;
  assign sreset = sreset_q;
  assign txenable = txen_q;
  assign ready = ready_q;
  assign state = state_q;
  assign underflow_cnt = uf_q;
endmodule

// File: tb/tb_dac_ddr_tx.sv
// tb_dac_ddr_tx: self-checking bench for dac_ddr_tx (table vectors, random traffic vs. reference model).
module tb_dac_ddr_tx;
  localparam int N = 12;
  logic clk = 1'b0;
  logic user_rst = 1'b1, user_start = 1'b0, user_sync_req = 1'b0, data_valid = 1'b0;
  logic [N-1:0] da_0 = '0, da_1 = '0, db_0 = '0, db_1 = '0;
`ifdef DAC_DDR_TX_RAMP_EN
  logic user_ramp = 1'b0;
`endif
  logic ready, sreset, txenable, sync_p, sync_n, dacclk_p, dacclk_n;
  logic [2:0] state;
  logic [15:0] underflow_cnt;
  logic [N-1:0] da_p, da_n, db_p, db_n;
  logic ready1, sreset1, txenable1, sync_p1, sync_n1, dacclk_p1, dacclk_n1;
  logic [2:0] state1;
  logic [15:0] underflow_cnt1;
  logic [N-1:0] da_p1, da_n1, db_p1, db_n1;

  always #5 clk = ~clk;

  dac_ddr_tx dut (
    .clk(clk), .user_rst(user_rst), .user_start(user_start), .user_sync_req(user_sync_req),
`ifdef DAC_DDR_TX_RAMP_EN
    .user_ramp(user_ramp),
`endif
    .data_valid(data_valid), .da_0(da_0), .da_1(da_1), .db_0(db_0), .db_1(db_1),
    .ready(ready), .state(state), .underflow_cnt(underflow_cnt), .sreset(sreset),
    .txenable(txenable), .sync_p(sync_p), .sync_n(sync_n), .dacclk_p(dacclk_p),
    .dacclk_n(dacclk_n), .da_p(da_p), .da_n(da_n), .db_p(db_p), .db_n(db_n)
  );

  dac_ddr_tx #(.OFFSET_BINARY(1'b0)) u1 (
    .clk(clk), .user_rst(user_rst), .user_start(user_start), .user_sync_req(user_sync_req),
`ifdef DAC_DDR_TX_RAMP_EN
    .user_ramp(user_ramp),
`endif
    .data_valid(data_valid), .da_0(da_0), .da_1(da_1), .db_0(db_0), .db_1(db_1),
    .ready(ready1), .state(state1), .underflow_cnt(underflow_cnt1), .sreset(sreset1),
    .txenable(txenable1), .sync_p(sync_p1), .sync_n(sync_n1), .dacclk_p(dacclk_p1),
    .dacclk_n(dacclk_n1), .da_p(da_p1), .da_n(da_n1), .db_p(db_p1), .db_n(db_n1)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words as seen two's-complement at stage-1 capture, delayed two clocks to the pins.
  logic [4*N-1:0] hist[$];
  logic [4*N-1:0] cur;
  int sl, uf;
  logic [N-1:0] r;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic tick_rise;
    logic [4*N-1:0] w;
    logic [N-1:0] r1;
    logic rmp;
    @(posedge clk);
    w = '0;
    rmp = 1'b0;
`ifdef DAC_DDR_TX_RAMP_EN
    rmp = user_ramp;
`endif
    if (sl == 0) begin
      if (rmp) begin
        r1 = r + 12'd1;
        w = {r, r1, r, r1};
        r = r + 12'd2;
      end else if (data_valid) w = {da_0, da_1, db_0, db_1};
      else if (uf < 65535) uf++;
      if (user_sync_req) sl = 16;
    end else begin
      sl--;
      r = '0;
    end
    hist.push_back(w);
    cur = hist.pop_front();
    #1;
    chk("a_rise", da_p, cur[47:36] ^ 12'h800);
    chk("b_rise", db_p, cur[23:12] ^ 12'h800);
    chk("a_n_rise", da_n ^ cur[47:36], 32'h7FF);
    chk("a_rise_tc", da_p1, cur[47:36]);
    chk("b_rise_tc", db_p1, cur[23:12]);
    chk("state", state, sl != 0 ? 3 : 4);
    chk("ready", ready, sl == 0);
    chk("sync_p", sync_p, sl != 0);
    chk("sync_n", sync_n, sl == 0);
    chk("txenable", txenable, 1);
    chk("sreset", sreset, 1);
    chk("underflow", underflow_cnt, uf);
    chk("dacclk_rise", dacclk_p, 1);
  endtask

  task automatic tick_fall;
    @(negedge clk);
    #1;
    chk("a_fall", da_p, cur[35:24] ^ 12'h800);
    chk("b_fall", db_p, cur[11:0] ^ 12'h800);
    chk("b_n_fall", db_n ^ cur[11:0], 32'h7FF);
    chk("a_fall_tc", da_p1, cur[35:24]);
    chk("b_fall_tc", db_p1, cur[11:0]);
    chk("dacclk_fall", dacclk_p, 0);
  endtask

  task automatic tick;
    tick_rise();
    tick_fall();
  endtask

  typedef struct {
    logic [N-1:0] a0, a1, b0, b1;
    logic v;
    logic [N-1:0] ra, fa, rb, fb;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int n;
    tbl[0] = '{12'h123, 12'h456, 12'h7FF, 12'h800, 1'b1, 12'h923, 12'hC56, 12'hFFF, 12'h000};
    tbl[1] = '{12'h000, 12'hFFF, 12'h001, 12'hABC, 1'b1, 12'h800, 12'h7FF, 12'h801, 12'h2BC};
    tbl[2] = '{12'h555, 12'hAAA, 12'h3C3, 12'hC3C, 1'b1, 12'hD55, 12'h2AA, 12'hBC3, 12'h43C};
    tbl[3] = '{12'h123, 12'h456, 12'h789, 12'hABC, 1'b0, 12'h800, 12'h800, 12'h800, 12'h800};
    tbl[4] = '{12'h800, 12'h7FF, 12'hFFF, 12'h000, 1'b1, 12'h000, 12'hFFF, 12'h7FF, 12'h800};
    tbl[5] = '{12'hFFE, 12'h001, 12'h234, 12'h567, 1'b1, 12'h7FE, 12'h801, 12'hA34, 12'hD67};

    repeat (3) step();
    user_rst = 1'b0;
    step();
    chk("rst_state", state, 0);
    chk("rst_sreset", sreset, 1);
    chk("rst_txen", txenable, 0);
    chk("rst_sync", sync_p, 0);
    chk("rst_ready", ready, 0);
    chk("rst_uf", underflow_cnt, 0);
    chk("rst_pin_a", da_p, 12'h800);
    chk("rst_pin_a_tc", da_p1, 12'h000);

    user_sync_req = 1'b1;
    step();
    user_sync_req = 1'b0;
    chk("idle_sync_ignored", state, 0);

    user_start = 1'b1;
    step();
    user_start = 1'b0;
    chk("start_state", state, 1);
    n = 0;
    while (sreset == 1'b0 && n < 1000) begin
      step();
      n++;
    end
    chk("sreset_low_len", n, 64);
    n = 0;
    while (state == 3'd2 && n < 1000) begin
      chk("settle_txen", txenable, 0);
      step();
      n++;
    end
    chk("settle_len", n, 256);
    chk("sync_txen", txenable, 0);
    chk("sync_state", state, 3);
    n = 0;
    while (sync_p == 1'b1 && n < 1000) begin
      step();
      n++;
    end
    chk("sync_len", n, 16);
    chk("run_state", state, 4);
    chk("run_ready", ready, 1);
    chk("run_txen", txenable, 1);
    chk("run_sreset", sreset, 1);

    hist = {};
    hist.push_back('0);
    hist.push_back('0);
    sl = 0;
    uf = 0;
    r = '0;

    data_valid = 1'b0;
    repeat (10) tick();
    chk("uf_10", underflow_cnt, 10);

    foreach (tbl[i]) begin
      {da_0, da_1, db_0, db_1, data_valid} = {tbl[i].a0, tbl[i].a1, tbl[i].b0, tbl[i].b1, tbl[i].v};
      tick();
      data_valid = 1'b0;
      tick();
      tick_rise();
      chk("tbl_a_rise", da_p, tbl[i].ra);
      chk("tbl_b_rise", db_p, tbl[i].rb);
      tick_fall();
      chk("tbl_a_fall", da_p, tbl[i].fa);
      chk("tbl_b_fall", db_p, tbl[i].fb);
    end

    for (int i = 0; i < 1500; i++) begin
      da_0 = N'($urandom);
      da_1 = N'($urandom);
      db_0 = N'($urandom);
      db_1 = N'($urandom);
      data_valid = $urandom_range(0, 3) != 0;
      user_sync_req = $urandom_range(0, 99) == 0;
      user_start = $urandom_range(0, 49) == 0;
      tick();
    end
    user_sync_req = 1'b0;
    user_start = 1'b0;
    repeat (20) tick();

    user_sync_req = 1'b1;
    tick();
    user_sync_req = 1'b0;
    chk("resync_ready", ready, 0);
    chk("resync_state", state, 3);
    chk("resync_txen", txenable, 1);
    repeat (16) tick();
    chk("resync_back_run", state, 4);
    user_start = 1'b1;
    tick();
    user_start = 1'b0;
    chk("run_start_ignored", state, 4);

`ifdef DAC_DDR_TX_RAMP_EN
    data_valid = 1'b0;
    user_ramp = 1'b1;
    repeat (3000) tick();
    user_ramp = 1'b0;
`endif

    data_valid = 1'b0;
    repeat (70000) tick();
    chk("uf_saturated", underflow_cnt, 16'hFFFF);

    user_rst = 1'b1;
    step();
    user_rst = 1'b0;
    chk("rerst_state", state, 0);
    user_start = 1'b1;
    step();
    user_start = 1'b0;
    repeat (64) step();
    chk("re_settle_state", state, 2);
    repeat (100) step();
    user_rst = 1'b1;
    step();
    user_rst = 1'b0;
    chk("abort_state", state, 0);
    chk("abort_sreset", sreset, 1);
    chk("abort_txen", txenable, 0);
    chk("abort_sync", sync_p, 0);
    chk("abort_ready", ready, 0);
    chk("abort_uf", underflow_cnt, 0);
    chk("abort_a_rise", da_p, 12'h800);
    chk("abort_b_rise", db_p, 12'h800);
    @(negedge clk);
    #1;
    chk("abort_a_fall", da_p, 12'h800);
    chk("abort_b_fall", db_p, 12'h800);
    chk("abort_a_fall_tc", da_p1, 12'h000);
    repeat (5) step();
    chk("abort_stays_idle", state, 0);
    chk("abort_stays_sreset", sreset, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
